csr_gpio_bank: RTL and testbench
================================

Name: csr_gpio_bank

Overview:
- Parametrised GPIO CSR peripheral on the MemSplit32-style bus (req/ack/we/addr/be/wdata/resp/rdata).
- Successor to the single fixed LED/SW register pair. Provides BANKS banks of GPIO_WIDTH bits, each with:
  - byte-enable writes and atomic set/clear of the output register;
  - an input synchroniser;
  - per-bit edge-detect interrupts with pending and enable registers.
- Sits on the tile's xif port. irq_o feeds the tile's IRQ inputs.

Parameters:
- BASE_ADDR, 32'h80000000, base of bank 0. Must be aligned to 32*2^clog2(BANKS).
- BANKS, 2, number of GPIO banks (1..8). Each bank occupies 32 bytes.
- GPIO_WIDTH, 32, bits per bank (1..32). Unused upper bits read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- clk_i  input  1  clock.
- arst_n_i  input  1  asynchronous active-low reset.
- bus_req_i  input  1  request.
- bus_we_i  input  1  1 = write, 0 = read.
- bus_addr_bi  input  32  byte address. Bits [1:0] are ignored.
- bus_be_bi  input  4  write byte enables.
- bus_wdata_bi  input  32  write data.
- bus_ack_o  output  1  request accepted.
- bus_resp_o  output  1  read data valid.
- bus_rdata_bo  output  32  read data.
- gpio_bi  input  BANKS*GPIO_WIDTH  asynchronous inputs. Bank b occupies slice [b*W +: W].
- gpio_bo  output  BANKS*GPIO_WIDTH  registered outputs.
- irq_o  output  BANKS  per-bank level interrupt, registered.

Behaviour:
- Reset (arst_n_i low, takes effect immediately) clears all of the following to 0:
  - all registers, synchroniser flops and the previous-sample register;
  - gpio_bo, irq_o, bus_resp_o and bus_rdata_bo.
- Handshake:
  - bus_ack_o = bus_req_i, combinationally; every request is accepted in its own cycle.
  - Writes take effect at the accepting clock edge and produce no resp.
  - Reads: bus_resp_o is high for exactly 1 cycle, the cycle after acceptance, with bus_rdata_bo valid. Otherwise bus_rdata_bo = 0.
  - Back-to-back reads give back-to-back resp pulses.
- Decode:
  - Hit when addr[31:5+clog2(BANKS)] matches BASE_ADDR; bank index = addr[5 +: clog2(BANKS)]; register offset = addr[4:2].
  - A bank index >= BANKS, or no address match, is unmapped: writes are dropped, reads still return resp=1 with rdata=0. The bus never hangs.
- Per-bank registers by offset (RW = byte-enable masked, per byte lane):
  - 0x00 OUT: RW. Drives gpio_bo.
  - 0x04 IN: RO. Returns the synchronised input. Writes are ignored.
  - 0x08 IRQ_EN: RW.
  - 0x0C IRQ_PEND: write-1-to-clear, byte masked. Reads return pending bits.
  - 0x10 RISE_EN: RW. Enables the rising-edge event.
  - 0x14 FALL_EN: RW. Enables the falling-edge event.
  - 0x18 OUT_SET: WO, reads 0. OUT |= wdata&bemask.
  - 0x1C OUT_CLR: WO, reads 0. OUT &= ~(wdata&bemask).
- Input path:
  - gpio_bi passes through SYNC_STAGES flops to give s; p is s delayed by one cycle.
  - rise = s&~p; fall = ~s&p.
  - event = (rise&RISE_EN) | (fall&FALL_EN).
  - IN reflects s: a change at edge k is readable once stage SYNC_STAGES has captured it.
- Pending:
  - PEND_next = (PEND & ~w1c_mask) | event.
  - When a set and a clear hit the same bit in the same cycle, the set wins.
  - Pending latches regardless of IRQ_EN.
- Post-reset arming:
  - A counter suppresses events for SYNC_STAGES+1 cycles after reset release.
  - This prevents spurious rise events from inputs already high.
- Interrupt: irq_o[b] <= |(PEND_b & IRQ_EN_b), registered, so it follows a pending or enable change by 1 cycle.
  - Enabling IRQ_EN while PEND is already set raises irq_o on the next cycle.
- Edge enables: both RISE_EN and FALL_EN set means any edge. Neither set means no events, but IN remains readable.
- Reset mid-operation: a read accepted in the reset cycle produces no resp. Pending state is lost.

Test Plan:
1. Reset, then read bank0 OUT/IN/IRQ_EN/IRQ_PEND -> resp=1 one cycle after req each time, rdata=0. gpio_bo=0, irq_o=0.
2. Write 0x80000000 = 0xA5A5A5A5 with be=4'b0010 -> OUT=0x0000A500. Then OUT_SET(0x80000018) 0x0000000F, be=F -> OUT=0x0000A50F. Then OUT_CLR(0x8000001C) 0x00000005 -> OUT=0x0000A50A. Then read bank1 OUT (0x80000020) -> 0.
3. RISE_EN=0x1, IRQ_EN=0x1; drive gpio_bi[0] 0->1 -> PEND bit0 set SYNC_STAGES+1 cycles after the change, irq_o[0] one cycle later. Write PEND=0x1 -> irq_o[0] drops 1 cycle after PEND clears.
4. FALL_EN=0x2, IRQ_EN=0; drive bit1 1->0 -> PEND=0x2, irq_o=0. Then write IRQ_EN=0x2 -> irq_o[0]=1 on the next cycle.
5. Make a W1C of bit0 coincide with a new rise event on bit0 -> PEND bit0 stays 1.
6. Hold gpio_bi=all-ones through reset release with RISE_EN=all-ones preloaded after reset -> PEND stays 0. Then read 0x80000040 with BANKS=2 (unmapped) -> resp=1, rdata=0. Then write to it -> no register changes.

Source files
------------

// File: rtl/csr_gpio_bank.sv
// ---------------------------------------------------------------------------
// csr_gpio_bank
//   Parametrised GPIO CSR peripheral on a req/ack split read bus. It provides
//   BANKS banks of GPIO_WIDTH bits. Each bank has:
//     - a byte-enable masked output register, with atomic set and clear aliases;
//     - an input synchroniser;
//     - per-bit rising/falling edge events that latch into a pending register;
//     - a per-bank interrupt, gated by an enable mask.
//
//   Register map per bank (bank b sits at BASE_ADDR + 32*b):
//     0x00 OUT       RW   drives gpio_bo
//     0x04 IN        RO   synchronised input
//     0x08 IRQ_EN    RW
//     0x0C IRQ_PEND  W1C  reads pending bits
//     0x10 RISE_EN   RW
//     0x14 FALL_EN   RW
//     0x18 OUT_SET   WO   OUT |= data, reads 0
//     0x1C OUT_CLR   WO   OUT &= ~data, reads 0
//
// Ports
//   clk_i          clock
//   arst_n_i       asynchronous active-low reset
//   bus_req_i      request
//   bus_we_i       1 = write, 0 = read
//   bus_addr_bi    byte address; bits [1:0] are ignored
//   bus_be_bi      write byte enables
//   bus_wdata_bi   write data
//   bus_ack_o      request accepted (same cycle, combinational)
//   bus_resp_o     read data valid, one cycle after a read is accepted
//   bus_rdata_bo   read data; 0 whenever bus_resp_o is low
//   gpio_bi        asynchronous inputs; bank b is slice [b*GPIO_WIDTH +: GPIO_WIDTH]
//   gpio_bo        registered outputs, same packing as gpio_bi
//   irq_o          per-bank level interrupt, registered
// ---------------------------------------------------------------------------
module csr_gpio_bank #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          BANKS       = 2,
    parameter int          GPIO_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        arst_n_i,
    input  logic                        bus_req_i,
    input  logic                        bus_we_i,
    input  logic [31:0]                 bus_addr_bi,
    input  logic [3:0]                  bus_be_bi,
    input  logic [31:0]                 bus_wdata_bi,
    output logic                        bus_ack_o,
    output logic                        bus_resp_o,
    output logic [31:0]                 bus_rdata_bo,
    input  logic [BANKS*GPIO_WIDTH-1:0] gpio_bi,
    output logic [BANKS*GPIO_WIDTH-1:0] gpio_bo,
    output logic [BANKS-1:0]            irq_o
);

    localparam int          BANK_BITS = $clog2(BANKS);
    localparam int          MATCH_LSB = 5 + BANK_BITS;
    localparam int          NW        = BANKS * GPIO_WIDTH;
    localparam logic [31:0] BANK_MASK = (32'd1 << BANK_BITS) - 32'd1;
    // Events stay masked until the synchroniser and the previous-sample
    // register hold real input values, so inputs that are already high at
    // reset release do not look like rising edges.
    localparam logic [2:0]  ARM_INIT  = 3'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        OFF_OUT      = 3'd0,
        OFF_IN       = 3'd1,
        OFF_IRQ_EN   = 3'd2,
        OFF_IRQ_PEND = 3'd3,
        OFF_RISE_EN  = 3'd4,
        OFF_FALL_EN  = 3'd5,
        OFF_OUT_SET  = 3'd6,
        OFF_OUT_CLR  = 3'd7
    } reg_off_e;

    // ------------------------------------------------------------------
    // Address decode and write data masking
    // ------------------------------------------------------------------
    logic                  addr_hit;
    logic [31:0]           bank_sel;
    reg_off_e              reg_off;
    logic                  wr_en;
    logic                  rd_en;
    logic [31:0]           be_mask32;
    logic [31:0]           wdata_m32;
    logic [GPIO_WIDTH-1:0] be_mask;
    logic [GPIO_WIDTH-1:0] wbits;

    // The high address bits are compared against BASE_ADDR. Alignment of
    // BASE_ADDR keeps the bank field out of that comparison.
    assign addr_hit  = ((bus_addr_bi ^ BASE_ADDR) >> MATCH_LSB) == 32'd0;
    // Bank indices past BANKS-1 simply match no bank below, so they decode
    // as unmapped without any extra logic.
    assign bank_sel  = (bus_addr_bi >> 5) & BANK_MASK;
    assign reg_off   = reg_off_e'(bus_addr_bi[4:2]);
    assign wr_en     = bus_req_i & bus_we_i & addr_hit;
    assign rd_en     = bus_req_i & ~bus_we_i;

    assign be_mask32 = {{8{bus_be_bi[3]}}, {8{bus_be_bi[2]}},
                        {8{bus_be_bi[1]}}, {8{bus_be_bi[0]}}};
    assign wdata_m32 = bus_wdata_bi & be_mask32;
    assign be_mask   = be_mask32[GPIO_WIDTH-1:0];
    assign wbits     = wdata_m32[GPIO_WIDTH-1:0];

    assign bus_ack_o = bus_req_i;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [GPIO_WIDTH-1:0] out_q     [BANKS];
    logic [GPIO_WIDTH-1:0] out_d     [BANKS];
    logic [GPIO_WIDTH-1:0] irq_en_q  [BANKS];
    logic [GPIO_WIDTH-1:0] irq_en_d  [BANKS];
    logic [GPIO_WIDTH-1:0] pend_q    [BANKS];
    logic [GPIO_WIDTH-1:0] pend_d    [BANKS];
    logic [GPIO_WIDTH-1:0] rise_en_q [BANKS];
    logic [GPIO_WIDTH-1:0] rise_en_d [BANKS];
    logic [GPIO_WIDTH-1:0] fall_en_q [BANKS];
    logic [GPIO_WIDTH-1:0] fall_en_d [BANKS];
    logic [BANKS-1:0]      irq_q;
    logic [BANKS-1:0]      irq_d;

    logic [NW-1:0]         sync_q    [SYNC_STAGES];
    logic [NW-1:0]         sync_s;
    logic [NW-1:0]         prev_q;

    logic [2:0]            arm_cnt_q;
    logic [2:0]            arm_cnt_d;
    logic                  armed;

    logic                  resp_q;
    logic                  resp_d;
    logic [31:0]           rdata_q;
    logic [31:0]           rdata_d;
    logic [31:0]           rd_val;

    logic [GPIO_WIDTH-1:0] in_s      [BANKS];
    logic [GPIO_WIDTH-1:0] in_p      [BANKS];
    logic [GPIO_WIDTH-1:0] evt       [BANKS];

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign armed  = (arm_cnt_q == 3'd0);

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        assign in_s[g] = sync_s[g*GPIO_WIDTH +: GPIO_WIDTH];
        assign in_p[g] = prev_q[g*GPIO_WIDTH +: GPIO_WIDTH];
        assign evt[g]  = armed ? ((in_s[g] & ~in_p[g] & rise_en_q[g]) |
                                  (~in_s[g] & in_p[g] & fall_en_q[g]))
                               : '0;
        assign gpio_bo[g*GPIO_WIDTH +: GPIO_WIDTH] = out_q[g];
    end

    assign irq_o        = irq_q;
    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;

    // ------------------------------------------------------------------
    // Register next-state
    // ------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            out_d[b]     = out_q[b];
            irq_en_d[b]  = irq_en_q[b];
            rise_en_d[b] = rise_en_q[b];
            fall_en_d[b] = fall_en_q[b];
            // A new event always lands, even on a bit being cleared in the
            // same cycle, so an edge is never lost to a racing W1C.
            pend_d[b]    = pend_q[b] | evt[b];
            irq_d[b]     = |(pend_q[b] & irq_en_q[b]);

            if (wr_en && (bank_sel == 32'(b))) begin
                unique case (reg_off)
                    OFF_OUT:      out_d[b]     = (out_q[b] & ~be_mask) | wbits;
                    OFF_IN:       ;
                    OFF_IRQ_EN:   irq_en_d[b]  = (irq_en_q[b] & ~be_mask) | wbits;
                    OFF_IRQ_PEND: pend_d[b]    = (pend_q[b] & ~wbits) | evt[b];
                    OFF_RISE_EN:  rise_en_d[b] = (rise_en_q[b] & ~be_mask) | wbits;
                    OFF_FALL_EN:  fall_en_d[b] = (fall_en_q[b] & ~be_mask) | wbits;
                    OFF_OUT_SET:  out_d[b]     = out_q[b] | wbits;
                    OFF_OUT_CLR:  out_d[b]     = out_q[b] & ~wbits;
                    default:      ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and response pipeline
    // ------------------------------------------------------------------
    always_comb begin
        rd_val = 32'd0;
        if (addr_hit) begin
            for (int b = 0; b < BANKS; b++) begin
                if (bank_sel == 32'(b)) begin
                    unique case (reg_off)
                        OFF_OUT:      rd_val = 32'(out_q[b]);
                        OFF_IN:       rd_val = 32'(in_s[b]);
                        OFF_IRQ_EN:   rd_val = 32'(irq_en_q[b]);
                        OFF_IRQ_PEND: rd_val = 32'(pend_q[b]);
                        OFF_RISE_EN:  rd_val = 32'(rise_en_q[b]);
                        OFF_FALL_EN:  rd_val = 32'(fall_en_q[b]);
                        default:      rd_val = 32'd0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        resp_d  = rd_en;
        rdata_d = rd_en ? rd_val : 32'd0;
    end

    always_comb begin
        arm_cnt_d = armed ? 3'd0 : (arm_cnt_q - 3'd1);
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int b = 0; b < BANKS; b++) begin
                out_q[b]     <= '0;
                irq_en_q[b]  <= '0;
                pend_q[b]    <= '0;
                rise_en_q[b] <= '0;
                fall_en_q[b] <= '0;
            end
            irq_q <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                out_q[b]     <= out_d[b];
                irq_en_q[b]  <= irq_en_d[b];
                pend_q[b]    <= pend_d[b];
                rise_en_q[b] <= rise_en_d[b];
                fall_en_q[b] <= fall_en_d[b];
            end
            irq_q <= irq_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_bi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_s;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            arm_cnt_q <= ARM_INIT;
            resp_q    <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_csr_gpio_bank.sv
module tb_csr_gpio_bank;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          BANKS = 2;
    localparam int          W     = 32;
    localparam int          S     = 2;

    logic        clk    = 1'b0;
    logic        arst_n = 1'b0;
    logic        req    = 1'b0;
    logic        we     = 1'b0;
    logic [31:0] addr   = 32'd0;
    logic [3:0]  be     = 4'd0;
    logic [31:0] wdata  = 32'd0;
    logic [63:0] gpio   = 64'd0;

    logic        ack;
    logic        resp;
    logic [31:0] rdata;
    logic [63:0] gpio_o;
    logic [1:0]  irq;

    int n_checks = 0;
    int n_errors = 0;

    csr_gpio_bank #(
        .BASE_ADDR  (BASE),
        .BANKS      (BANKS),
        .GPIO_WIDTH (W),
        .SYNC_STAGES(S)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .bus_req_i   (req),
        .bus_we_i    (we),
        .bus_addr_bi (addr),
        .bus_be_bi   (be),
        .bus_wdata_bi(wdata),
        .bus_ack_o   (ack),
        .bus_resp_o  (resp),
        .bus_rdata_bo(rdata),
        .gpio_bi     (gpio),
        .gpio_bo     (gpio_o),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] m_out  [BANKS];
    logic [31:0] m_ien  [BANKS];
    logic [31:0] m_pend [BANKS];
    logic [31:0] m_rise [BANKS];
    logic [31:0] m_fall [BANKS];
    logic [1:0]  m_irq;
    logic        m_resp;
    logic [31:0] m_rdata;
    logic [63:0] m_s, m_p;
    logic [63:0] pipe[$];
    int          n_edges;

    task automatic model_reset();
        for (int b = 0; b < BANKS; b++) begin
            m_out[b] = 0; m_ien[b] = 0; m_pend[b] = 0; m_rise[b] = 0; m_fall[b] = 0;
        end
        m_irq = 0; m_resp = 0; m_rdata = 0; m_s = 0; m_p = 0;
        pipe.delete();
        for (int i = 0; i < S - 1; i++) pipe.push_back(64'd0);
        n_edges = 0;
    endtask

    task automatic model_edge(input logic rn, input logic r, input logic w,
                              input logic [31:0] a, input logic [3:0] bm,
                              input logic [31:0] d, input logic [63:0] g);
        logic [31:0] m, wm, rd, sb, pb;
        logic [31:0] ev [BANKS];
        logic [31:0] pn [BANKS];
        logic [1:0]  irq_n;
        logic [63:0] ns;
        logic [31:0] rel;
        int          mapped, bank, off;
        if (!rn) begin
            model_reset();
            return;
        end
        m   = {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
        wm  = d & m;
        rel = a - BASE;
        mapped = (a >= BASE) && (rel < BANKS * 32);
        bank = int'(rel / 32) % BANKS;
        off  = int'((rel % 32) / 4);
        rd = 0;
        if (mapped) begin
            case (off)
                0: rd = m_out[bank];
                1: rd = m_s[bank*32 +: 32];
                2: rd = m_ien[bank];
                3: rd = m_pend[bank];
                4: rd = m_rise[bank];
                5: rd = m_fall[bank];
                default: rd = 0;
            endcase
        end
        for (int b = 0; b < BANKS; b++) begin
            sb = m_s[b*32 +: 32];
            pb = m_p[b*32 +: 32];
            ev[b] = (n_edges >= S + 1) ? ((sb & ~pb & m_rise[b]) | (~sb & pb & m_fall[b])) : 32'd0;
            irq_n[b] = (m_pend[b] & m_ien[b]) != 0;
            pn[b] = m_pend[b] | ev[b];
        end
        if (r && w && mapped) begin
            case (off)
                0: m_out[bank]  = (m_out[bank] & ~m) | wm;
                2: m_ien[bank]  = (m_ien[bank] & ~m) | wm;
                3: pn[bank]     = (m_pend[bank] & ~wm) | ev[bank];
                4: m_rise[bank] = (m_rise[bank] & ~m) | wm;
                5: m_fall[bank] = (m_fall[bank] & ~m) | wm;
                6: m_out[bank]  = m_out[bank] | wm;
                7: m_out[bank]  = m_out[bank] & ~wm;
                default: ;
            endcase
        end
        for (int b = 0; b < BANKS; b++) m_pend[b] = pn[b];
        m_irq   = irq_n;
        m_resp  = r && !w;
        m_rdata = (r && !w) ? rd : 32'd0;
        pipe.push_back(g);
        ns  = pipe.pop_front();
        m_p = m_s;
        m_s = ns;
        if (n_edges < 1000) n_edges++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        logic rn = arst_n, r = req, w = we;
        logic [31:0] a = addr, d = wdata;
        logic [3:0]  bm = be;
        logic [63:0] g = gpio;
        @(posedge clk);
        model_edge(rn, r, w, a, bm, d, g);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bm);
        req = 1; we = 1; addr = a; wdata = d; be = bm;
        tick();
        req = 0; we = 0; wdata = 0; be = 0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        req = 1; we = 0; addr = a;
        tick();
        req = 0;
    endtask

    task automatic apply_reset(input logic [63:0] g);
        req = 0; we = 0; gpio = g;
        arst_n = 0;
        model_reset();
        idle(3);
        #2 arst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        gpio = 0; req = 0; arst_n = 0;
        model_reset();
        idle(2);
        n_checks++; if (gpio_o !== 64'd0) begin n_errors++; $display("FAIL reset_gpio_bo got=%h exp=0", gpio_o); end
        n_checks++; if (irq !== 2'b00) begin n_errors++; $display("FAIL reset_irq got=%b exp=00", irq); end
        n_checks++; if (resp !== 1'b0) begin n_errors++; $display("FAIL reset_resp got=%b exp=0", resp); end
        n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        #2 arst_n = 1;
        for (int k = 0; k < 4; k++) begin
            bus_read(BASE + 32'(4 * k));
            n_checks++; if (resp !== 1'b1) begin n_errors++; $display("FAIL reset_read_resp off=%0d got=%b exp=1", 4*k, resp); end
            n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL reset_read_data off=%0d got=%h exp=0", 4*k, rdata); end
            tick();
            n_checks++; if (resp !== 1'b0) begin n_errors++; $display("FAIL reset_read_pulse off=%0d got=%b exp=0", 4*k, resp); end
        end
    endtask

    task automatic test_out_write();
        bus_write(BASE, 32'hA5A5A5A5, 4'b0010);
        n_checks++; if (gpio_o[31:0] !== 32'h0000A500) begin n_errors++; $display("FAIL out_be got=%h exp=0000a500", gpio_o[31:0]); end
        n_checks++; if (resp !== 1'b0) begin n_errors++; $display("FAIL write_no_resp got=%b exp=0", resp); end
        bus_write(BASE + 32'h18, 32'h0000000F, 4'hF);
        n_checks++; if (gpio_o[31:0] !== 32'h0000A50F) begin n_errors++; $display("FAIL out_set got=%h exp=0000a50f", gpio_o[31:0]); end
        bus_write(BASE + 32'h1C, 32'h00000005, 4'hF);
        n_checks++; if (gpio_o[31:0] !== 32'h0000A50A) begin n_errors++; $display("FAIL out_clr got=%h exp=0000a50a", gpio_o[31:0]); end
        req = 1; we = 0; addr = BASE + 32'h20;
        #1;
        n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL ack_high got=%b exp=1", ack); end
        tick();
        req = 0;
        n_checks++; if (rdata !== 32'd0 || resp !== 1'b1) begin n_errors++; $display("FAIL bank1_out got=%h/%b exp=0/1", rdata, resp); end
        #1;
        n_checks++; if (ack !== 1'b0) begin n_errors++; $display("FAIL ack_low got=%b exp=0", ack); end
        n_checks++; if (gpio_o[63:32] !== 32'd0) begin n_errors++; $display("FAIL bank1_gpio got=%h exp=0", gpio_o[63:32]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq_a [3];
        logic [31:0] seq_e [3];
        seq_a[0] = BASE;           seq_e[0] = 32'h0000A50A;
        seq_a[1] = BASE + 32'h18;  seq_e[1] = 32'd0;
        seq_a[2] = BASE;           seq_e[2] = 32'h0000A50A;
        req = 1; we = 0;
        for (int i = 0; i < 3; i++) begin
            addr = seq_a[i];
            tick();
            n_checks++; if (resp !== 1'b1 || rdata !== seq_e[i]) begin n_errors++; $display("FAIL b2b_read%0d got=%b/%h exp=1/%h", i, resp, rdata, seq_e[i]); end
        end
        req = 0;
        tick();
        n_checks++; if (resp !== 1'b0 || rdata !== 32'd0) begin n_errors++; $display("FAIL b2b_idle got=%b/%h exp=0/0", resp, rdata); end
    endtask

    task automatic test_rise_irq();
        bus_write(BASE + 32'h10, 32'h1, 4'hF);
        bus_write(BASE + 32'h08, 32'h1, 4'hF);
        gpio[0] = 1'b1;
        idle(S + 1);
        n_checks++; if (irq[0] !== 1'b0) begin n_errors++; $display("FAIL rise_irq_early got=%b exp=0", irq[0]); end
        bus_read(BASE + 32'h0C);
        n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL rise_pend got=%h exp=1", rdata); end
        n_checks++; if (irq[0] !== 1'b1) begin n_errors++; $display("FAIL rise_irq got=%b exp=1", irq[0]); end
        bus_read(BASE + 32'h04);
        n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL in_read got=%h exp=1", rdata); end
        bus_write(BASE + 32'h0C, 32'h1, 4'hF);
        n_checks++; if (irq[0] !== 1'b1) begin n_errors++; $display("FAIL w1c_irq_lag got=%b exp=1", irq[0]); end
        tick();
        n_checks++; if (irq[0] !== 1'b0) begin n_errors++; $display("FAIL w1c_irq_drop got=%b exp=0", irq[0]); end
    endtask

    task automatic test_fall_irq_enable();
        bus_write(BASE + 32'h14, 32'h2, 4'hF);
        bus_write(BASE + 32'h08, 32'h0, 4'hF);
        gpio[1] = 1'b1;
        idle(S + 2);
        gpio[1] = 1'b0;
        idle(S + 1);
        bus_read(BASE + 32'h0C);
        n_checks++; if (rdata !== 32'h2) begin n_errors++; $display("FAIL fall_pend got=%h exp=2", rdata); end
        n_checks++; if (irq[0] !== 1'b0) begin n_errors++; $display("FAIL fall_irq_disabled got=%b exp=0", irq[0]); end
        bus_write(BASE + 32'h08, 32'h2, 4'hF);
        n_checks++; if (irq[0] !== 1'b0) begin n_errors++; $display("FAIL en_irq_lag got=%b exp=0", irq[0]); end
        tick();
        n_checks++; if (irq[0] !== 1'b1) begin n_errors++; $display("FAIL en_irq_rise got=%b exp=1", irq[0]); end
    endtask

    task automatic test_set_wins();
        gpio[0] = 1'b0;
        idle(S + 2);
        gpio[0] = 1'b1;
        idle(S);
        bus_write(BASE + 32'h0C, 32'h1, 4'hF);
        bus_read(BASE + 32'h0C);
        n_checks++; if (rdata !== 32'h3) begin n_errors++; $display("FAIL set_wins_pend got=%h exp=3", rdata); end
        n_checks++; if (rdata !== m_rdata) begin n_errors++; $display("FAIL set_wins_model got=%h exp=%h", rdata, m_rdata); end
    endtask

    task automatic test_reset_mid();
        req = 1; we = 0; addr = BASE;
        #2 arst_n = 0;
        #1;
        n_checks++; if (gpio_o !== 64'd0 || irq !== 2'b00) begin n_errors++; $display("FAIL async_reset got=%h/%b exp=0/00", gpio_o, irq); end
        tick();
        n_checks++; if (resp !== 1'b0 || rdata !== 32'd0) begin n_errors++; $display("FAIL reset_read_no_resp got=%b/%h exp=0/0", resp, rdata); end
        req = 0;
        #2 arst_n = 1;
        bus_read(BASE + 32'h0C);
        n_checks++; if (resp !== 1'b1 || rdata !== 32'd0) begin n_errors++; $display("FAIL pend_lost got=%b/%h exp=1/0", resp, rdata); end
    endtask

    task automatic test_arming_unmapped();
        apply_reset(64'hFFFF_FFFF_FFFF_FFFF);
        bus_write(BASE + 32'h10, 32'hFFFFFFFF, 4'hF);
        bus_write(BASE + 32'h30, 32'hFFFFFFFF, 4'hF);
        idle(4);
        bus_read(BASE + 32'h0C);
        n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL arm_pend_b0 got=%h exp=0", rdata); end
        bus_read(BASE + 32'h2C);
        n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL arm_pend_b1 got=%h exp=0", rdata); end
        bus_read(BASE + 32'h04);
        n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL arm_in got=%h exp=ffffffff", rdata); end
        bus_read(BASE + 32'h40);
        n_checks++; if (resp !== 1'b1 || rdata !== 32'd0) begin n_errors++; $display("FAIL unmapped_read got=%b/%h exp=1/0", resp, rdata); end
        bus_write(BASE + 32'h40, 32'hFFFFFFFF, 4'hF);
        bus_write(BASE + 32'h58, 32'hFFFFFFFF, 4'hF);
        bus_write(32'h0000_0000, 32'hFFFFFFFF, 4'hF);
        tick();
        n_checks++; if (gpio_o !== 64'd0) begin n_errors++; $display("FAIL unmapped_write got=%h exp=0", gpio_o); end
        bus_read(BASE + 32'h2C);
        n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL unmapped_pend got=%h exp=0", rdata); end
    endtask

    task automatic test_random();
        logic [63:0] flip;
        int bank, off;
        apply_reset({$urandom, $urandom});
        for (int i = 0; i < 600; i++) begin
            req = ($urandom_range(0, 9) < 7);
            we  = $urandom_range(0, 1);
            bank = $urandom_range(0, 2);
            off  = $urandom_range(0, 7);
            addr = BASE + 32'(bank * 32 + off * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            be    = 4'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                flip = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
                gpio = gpio ^ flip;
            end
            #1;
            n_checks++; if (ack !== req) begin n_errors++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, ack, req); end
            tick();
            n_checks++; if (resp !== m_resp) begin n_errors++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", i, resp, m_resp); end
            n_checks++; if (rdata !== m_rdata) begin n_errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", i, rdata, m_rdata); end
            n_checks++; if (gpio_o !== {m_out[1], m_out[0]}) begin n_errors++; $display("FAIL rnd_gpio_bo cyc=%0d got=%h exp=%h", i, gpio_o, {m_out[1], m_out[0]}); end
            n_checks++; if (irq !== m_irq) begin n_errors++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); end
        end
        req = 0; we = 0;
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_back_to_back();
        test_rise_irq();
        test_fall_irq_enable();
        test_set_wins();
        test_reset_mid();
        test_arming_unmapped();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
